kgp_sequencer: RTL

- Multi-cycle control unit and program counter for the KGP-RISC datapath.
- Owns the PC register (drives the datapath's instruction address) and runs a fetch/decode/execute/mem/writeback FSM.
- Decodes opcode/funccode returned by the datapath into per-state control strobes.
- Supports free-run, single-step handshake and a halt instruction; counts retired instructions.

---
 rtl/kgp_pkg.sv | 76 +++++++
 rtl/kgp_decode.sv | 76 +++++++
 rtl/kgp_sequencer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/kgp_pkg.sv
// rtl/kgp_pkg.sv - shared opcodes, control codes, FSM states and control word for the KGP-RISC sequencer
package kgp_pkg;

    localparam logic [4:0] OP_ALU    = 5'b00000;
    localparam logic [4:0] OP_ADDI   = 5'b00001;
    localparam logic [4:0] OP_COMPI  = 5'b00010;
    localparam logic [4:0] OP_LW     = 5'b00011;
    localparam logic [4:0] OP_SW     = 5'b00100;
    localparam logic [4:0] OP_BR     = 5'b00101;
    localparam logic [4:0] OP_BRANCH = 5'b00110;
    localparam logic [4:0] OP_HALT   = 5'b11111;

    localparam logic [4:0] FN_ADD    = 5'd0;
    localparam logic [4:0] FN_COMP   = 5'd1;
    localparam logic [4:0] FN_AND    = 5'd2;
    localparam logic [4:0] FN_XOR    = 5'd3;
    localparam logic [4:0] FN_SHLL   = 5'd4;
    localparam logic [4:0] FN_SHRL   = 5'd5;
    localparam logic [4:0] FN_SHLLV  = 5'd6;
    localparam logic [4:0] FN_SHRLV  = 5'd7;
    localparam logic [4:0] FN_SHRA   = 5'd8;
    localparam logic [4:0] FN_SHRAV  = 5'd9;

    // funccode[2:0] of the BRANCH opcode
    localparam logic [2:0] BF_B      = 3'd0;
    localparam logic [2:0] BF_BL     = 3'd1;
    localparam logic [2:0] BF_BCY    = 3'd2;
    localparam logic [2:0] BF_BNCY   = 3'd3;
    localparam logic [2:0] BF_BLTZ   = 3'd4;
    localparam logic [2:0] BF_BZ     = 3'd5;
    localparam logic [2:0] BF_BNZ    = 3'd6;

    // branch class seen by the next-address logic; b and bl share a class, brLink tells them apart
    localparam logic [2:0] BR_NONE   = 3'd0;
    localparam logic [2:0] BR_JR     = 3'd1;
    localparam logic [2:0] BR_UNCOND = 3'd2;
    localparam logic [2:0] BR_CY     = 3'd3;
    localparam logic [2:0] BR_NCY    = 3'd4;
    localparam logic [2:0] BR_LTZ    = 3'd5;
    localparam logic [2:0] BR_Z      = 3'd6;
    localparam logic [2:0] BR_NZ     = 3'd7;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_COMP  = 3'd1;
    localparam logic [2:0] ALU_AND   = 3'd2;
    localparam logic [2:0] ALU_XOR   = 3'd3;
    localparam logic [2:0] ALU_SHL   = 3'd4;
    localparam logic [2:0] ALU_SRA   = 3'd5;

    localparam logic [1:0] SRC_REG   = 2'd0;
    localparam logic [1:0] SRC_IMM   = 2'd1;
    localparam logic [1:0] SRC_SHAMT = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT
    } state_t;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       alu_cin;
        logic       alu_dir;
        logic       alu_frc;
        logic [1:0] alu_src;
        logic [2:0] branch;
        logic       br_link;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       uses_mem;
        logic       uses_wb;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/kgp_decode.sv
// rtl/kgp_decode.sv - combinational opcode/funccode to control word and state path decode
module kgp_decode
    import kgp_pkg::*;
(
    input  logic [4:0] opcode,
    input  logic [4:0] funccode,
    output ctrl_t      ctrl,
    output logic       halt,
    output logic       illegal
);

    always_comb begin
        ctrl    = '0;
        halt    = 1'b0;
        illegal = 1'b0;
        case (opcode)
            OP_ALU: begin
                ctrl.reg_write = 1'b1;
                ctrl.uses_wb   = 1'b1;
                case (funccode)
                    FN_COMP:  begin ctrl.alu_op = ALU_COMP; ctrl.alu_cin = 1'b1; end
                    FN_AND:   ctrl.alu_op = ALU_AND;
                    FN_XOR:   ctrl.alu_op = ALU_XOR;
                    FN_SHLL:  begin ctrl.alu_op = ALU_SHL; ctrl.alu_src = SRC_SHAMT; end
                    FN_SHRL:  begin ctrl.alu_op = ALU_SHL; ctrl.alu_dir = 1'b1; ctrl.alu_src = SRC_SHAMT; end
                    FN_SHLLV: ctrl.alu_op = ALU_SHL;
                    FN_SHRLV: begin ctrl.alu_op = ALU_SHL; ctrl.alu_dir = 1'b1; end
                    FN_SHRA:  begin ctrl.alu_op = ALU_SRA; ctrl.alu_dir = 1'b1; ctrl.alu_src = SRC_SHAMT; end
                    FN_SHRAV: begin ctrl.alu_op = ALU_SRA; ctrl.alu_dir = 1'b1; end
                    default:  ctrl.alu_op = ALU_ADD;
                endcase
            end
            OP_ADDI, OP_COMPI: begin
                ctrl.alu_op    = (opcode == OP_COMPI) ? ALU_COMP : ALU_ADD;
                ctrl.alu_cin   = (opcode == OP_COMPI);
                ctrl.alu_frc   = 1'b1;
                ctrl.alu_src   = SRC_IMM;
                ctrl.reg_write = 1'b1;
                ctrl.uses_wb   = 1'b1;
            end
            OP_LW: begin
                ctrl.alu_op     = ALU_ADD;
                ctrl.alu_frc    = 1'b1;
                ctrl.alu_src    = SRC_IMM;
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.uses_mem   = 1'b1;
                ctrl.uses_wb    = 1'b1;
            end
            OP_SW: begin
                ctrl.alu_op    = ALU_ADD;
                ctrl.alu_frc   = 1'b1;
                ctrl.alu_src   = SRC_IMM;
                ctrl.mem_write = 1'b1;
                ctrl.uses_mem  = 1'b1;
            end
            OP_BR: ctrl.branch = BR_JR;
            OP_BRANCH: begin
                case (funccode[2:0])
                    BF_B:    ctrl.branch = BR_UNCOND;
                    BF_BL:   begin ctrl.branch = BR_UNCOND; ctrl.br_link = 1'b1; ctrl.reg_write = 1'b1; end
                    BF_BCY:  ctrl.branch = BR_CY;
                    BF_BNCY: ctrl.branch = BR_NCY;
                    BF_BLTZ: ctrl.branch = BR_LTZ;
                    BF_BZ:   ctrl.branch = BR_Z;
                    BF_BNZ:  ctrl.branch = BR_NZ;
                    default: ctrl.branch = BR_NONE;
                endcase
            end
            OP_HALT: halt    = 1'b1;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/kgp_sequencer.sv
// rtl/kgp_sequencer.sv - multi-cycle control FSM, program counter and retire counter for KGP-RISC
module kgp_sequencer
    import kgp_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          COUNT_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               step_req,
    output logic               step_ack,
    input  logic [4:0]         opcode,
    input  logic [4:0]         funccode,
    input  logic [31:0]        nextInstrAddr,
    output logic [31:0]        instrAddr,
    output logic [2:0]         ALUResOp,
    output logic               ALUCin,
    output logic               ALUDir,
    output logic               ALUFrc,
    output logic [1:0]         ALUSrc,
    output logic [2:0]         branch,
    output logic               brLink,
    output logic               memToReg,
    output logic               memRead,
    output logic               memWrite,
    output logic               regWrite,
    output logic               halted,
    output logic               illegal,
    output logic [COUNT_W-1:0] retired
);

    state_t              state;
    state_t              next_state;
    logic [31:0]         pc_q;
    logic [COUNT_W-1:0]  retired_q;
    logic                illegal_q;
    logic                step_ack_q;
    logic                stepping_q;
    logic [CTRL_W-1:0]   ctrl_word_q;
    ctrl_t               ctrl_q;
    ctrl_t               dec_ctrl;
    logic                dec_halt;
    logic                dec_illegal;
    logic                retire;
    logic                in_body;

    kgp_decode u_decode (
        .opcode  (opcode),
        .funccode(funccode),
        .ctrl    (dec_ctrl),
        .halt    (dec_halt),
        .illegal (dec_illegal)
    );

    assign ctrl_q = ctrl_t'(ctrl_word_q);

    always_comb begin
        next_state = state;
        retire     = 1'b0;
        case (state)
            ST_IDLE:   if (run || step_req) next_state = ST_FETCH;
            ST_FETCH:  next_state = ST_DECODE;
            ST_DECODE: next_state = dec_halt ? ST_HALT : ST_EXEC;
            ST_EXEC: begin
                if (ctrl_q.uses_mem)     next_state = ST_MEM;
                else if (ctrl_q.uses_wb) next_state = ST_WB;
                else                     retire     = 1'b1;
            end
            ST_MEM: begin
                if (ctrl_q.uses_wb) next_state = ST_WB;
                else                retire     = 1'b1;
            end
            ST_WB:   retire     = 1'b1;
            ST_HALT: next_state = ST_HALT;
            default: next_state = ST_IDLE;
        endcase
        if (retire) next_state = run ? ST_FETCH : ST_IDLE;
    end

    // ALU/branch fields hold across the whole body; write/read strobes are pinned to a single state
    always_comb begin
        in_body  = (state == ST_EXEC) || (state == ST_MEM) || (state == ST_WB);
        ALUResOp = in_body ? ctrl_q.alu_op  : 3'd0;
        ALUCin   = in_body && ctrl_q.alu_cin;
        ALUDir   = in_body && ctrl_q.alu_dir;
        ALUFrc   = in_body && ctrl_q.alu_frc;
        ALUSrc   = in_body ? ctrl_q.alu_src : 2'd0;
        branch   = in_body ? ctrl_q.branch  : 3'd0;
        brLink   = in_body && ctrl_q.br_link;
        memRead  = ctrl_q.mem_read   && (state == ST_MEM);
        memWrite = ctrl_q.mem_write  && (state == ST_MEM);
        memToReg = ctrl_q.mem_to_reg && (state == ST_WB);
        regWrite = ctrl_q.reg_write  && (ctrl_q.uses_wb ? (state == ST_WB) : (state == ST_EXEC));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            pc_q        <= RESET_PC;
            retired_q   <= '0;
            illegal_q   <= 1'b0;
            step_ack_q  <= 1'b0;
            stepping_q  <= 1'b0;
            ctrl_word_q <= '0;
        end else begin
            state      <= next_state;
            // only an instruction launched from IDLE in step mode earns an acknowledge
            step_ack_q <= retire && !run && stepping_q;
            if (state == ST_IDLE && next_state == ST_FETCH) stepping_q <= !run;
            if (state == ST_DECODE) begin
                ctrl_word_q <= dec_ctrl;
                if (dec_illegal) illegal_q <= 1'b1;
            end
            if (retire) begin
                pc_q      <= nextInstrAddr;
                retired_q <= retired_q + COUNT_W'(1);
            end
        end
    end

    assign instrAddr = pc_q;
    assign retired   = retired_q;
    assign illegal   = illegal_q;
    assign step_ack  = step_ack_q;
    assign halted    = (state == ST_HALT);

endmodule
